// File: rtl/tmu_ctrl.sv
// rtl/tmu_ctrl.sv - commit-stage trap/CSR sequencer: CSR-file handshake, trap entry/return, fetch redirect
// Optional TMU_VECTORED_EN: vectored interrupt redirect when mtvec mode is 01.
module tmu_ctrl (
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_i,
    input  logic        csr_valid_i,
    output logic        csr_ready_o,
    input  logic [11:0] csr_addr_i,
    input  logic [2:0]  csr_op_i,
    input  logic [31:0] csr_wdata_i,
    input  logic [29:0] commit_pc_i,
    output logic        csr_resp_valid_o,
    output logic [31:0] csr_rdata_o,
    input  logic        excp_valid_i,
    input  logic [3:0]  excp_code_i,
    input  logic [31:0] excp_tval_i,
    input  logic        mret_i,
    output logic        tmu_valid_o,
    output logic [11:0] tmu_address_o,
    output logic [1:0]  tmu_opcode_o,
    output logic        tmu_wr_en_o,
    output logic [31:0] tmu_data_o,
    input  logic        tmu_done_i,
    input  logic        tmu_excp_i,
    input  logic [31:0] tmu_rdata_i,
    output logic        take_exception_o,
    output logic        take_interrupt_o,
    output logic        mret_o,
    output logic [29:0] tmu_epc_o,
    output logic [31:0] tmu_mtval_o,
    output logic [3:0]  tmu_mcause_o,
    input  logic [2:0]  mip_i,
    input  logic        mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [29:0] mepc_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic [2:0] {IDLE, CSR_REQ, CSR_WAIT, CSR_RESP, PULSE, REDIR} state_t;
    typedef enum logic [1:0] {TRAP_EXC, TRAP_INT, TRAP_MRET} trap_t;

    state_t      state;
    trap_t       trap_kind;
    logic [29:0] req_pc;
    logic [3:0]  irq_cause;
    logic        irq_pending;
    logic [31:0] trap_target;

    assign csr_ready_o = (state == IDLE) & csr_valid_i & ~excp_valid_i & ~mret_i;
    assign irq_pending = mie_i & (|mip_i);

    // mip_i is {MEI,MTI,MSI}; external beats software beats timer
    always_comb begin
        irq_cause = 4'd7;
        if (mip_i[2])      irq_cause = 4'd11;
        else if (mip_i[0]) irq_cause = 4'd3;
    end

`ifdef TMU_VECTORED_EN
    always_comb begin
        trap_target = {mtvec_i[31:2], 2'b00};
        case (trap_kind)
            TRAP_MRET: trap_target = {mepc_i, 2'b00};
            TRAP_INT:  if (mtvec_i[1:0] == 2'b01)
                           trap_target = {mtvec_i[31:2] + {26'd0, tmu_mcause_o}, 2'b00};
            default:   trap_target = {mtvec_i[31:2], 2'b00};
        endcase
    end
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_i[1:0];

    always_comb begin
        trap_target = {mtvec_i[31:2], 2'b00};
        if (trap_kind == TRAP_MRET)
            trap_target = {mepc_i, 2'b00};
    end
`endif

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            state            <= IDLE;
            trap_kind        <= TRAP_EXC;
            req_pc           <= '0;
            csr_resp_valid_o <= 1'b0;
            csr_rdata_o      <= '0;
            tmu_valid_o      <= 1'b0;
            tmu_address_o    <= '0;
            tmu_opcode_o     <= '0;
            tmu_wr_en_o      <= 1'b0;
            tmu_data_o       <= '0;
            take_exception_o <= 1'b0;
            take_interrupt_o <= 1'b0;
            mret_o           <= 1'b0;
            tmu_epc_o        <= '0;
            tmu_mtval_o      <= '0;
            tmu_mcause_o     <= '0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            tmu_valid_o      <= 1'b0;
            csr_resp_valid_o <= 1'b0;
            take_exception_o <= 1'b0;
            take_interrupt_o <= 1'b0;
            mret_o           <= 1'b0;
            redirect_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (excp_valid_i) begin
                        trap_kind        <= TRAP_EXC;
                        tmu_epc_o        <= commit_pc_i;
                        tmu_mtval_o      <= excp_tval_i;
                        tmu_mcause_o     <= excp_code_i;
                        take_exception_o <= 1'b1;
                        state            <= PULSE;
                    end else if (mret_i) begin
                        trap_kind <= TRAP_MRET;
                        mret_o    <= 1'b1;
                        state     <= PULSE;
                    end else if (csr_valid_i) begin
                        req_pc        <= commit_pc_i;
                        tmu_valid_o   <= 1'b1;
                        tmu_address_o <= csr_addr_i;
                        tmu_opcode_o  <= csr_op_i[1:0];
                        tmu_wr_en_o   <= csr_op_i[2];
                        tmu_data_o    <= csr_wdata_i;
                        state         <= CSR_REQ;
                    end else if (irq_pending) begin
                        trap_kind        <= TRAP_INT;
                        tmu_epc_o        <= commit_pc_i;
                        tmu_mtval_o      <= '0;
                        tmu_mcause_o     <= irq_cause;
                        take_interrupt_o <= 1'b1;
                        state            <= PULSE;
                    end
                end
                CSR_REQ: state <= CSR_WAIT;
                CSR_WAIT: begin
                    if (tmu_done_i) begin
                        if (tmu_excp_i) begin
                            // illegal CSR access traps at the instruction that issued it
                            trap_kind        <= TRAP_EXC;
                            tmu_epc_o        <= req_pc;
                            tmu_mtval_o      <= '0;
                            tmu_mcause_o     <= 4'd2;
                            take_exception_o <= 1'b1;
                            state            <= PULSE;
                        end else begin
                            csr_rdata_o      <= tmu_rdata_i;
                            csr_resp_valid_o <= 1'b1;
                            state            <= CSR_RESP;
                        end
                    end
                end
                CSR_RESP: state <= IDLE;
                PULSE: begin
                    redirect_valid_o <= 1'b1;
                    redirect_pc_o    <= trap_target;
                    state            <= REDIR;
                end
                REDIR:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmu_ctrl.sv
// tb/tb_tmu_ctrl.sv - directed self-checking bench for tmu_ctrl
module tb_tmu_ctrl;

    logic        cpu_clock_i = 1'b0;
    logic        cpu_reset_i = 1'b0;
    logic        csr_valid_i = 1'b0;
    logic        csr_ready_o;
    logic [11:0] csr_addr_i = '0;
    logic [2:0]  csr_op_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic [29:0] commit_pc_i = '0;
    logic        csr_resp_valid_o;
    logic [31:0] csr_rdata_o;
    logic        excp_valid_i = 1'b0;
    logic [3:0]  excp_code_i = '0;
    logic [31:0] excp_tval_i = '0;
    logic        mret_i = 1'b0;
    logic        tmu_valid_o;
    logic [11:0] tmu_address_o;
    logic [1:0]  tmu_opcode_o;
    logic        tmu_wr_en_o;
    logic [31:0] tmu_data_o;
    logic        tmu_done_i = 1'b0;
    logic        tmu_excp_i = 1'b0;
    logic [31:0] tmu_rdata_i = '0;
    logic        take_exception_o;
    logic        take_interrupt_o;
    logic        mret_o;
    logic [29:0] tmu_epc_o;
    logic [31:0] tmu_mtval_o;
    logic [3:0]  tmu_mcause_o;
    logic [2:0]  mip_i = '0;
    logic        mie_i = 1'b0;
    logic [31:0] mtvec_i = '0;
    logic [29:0] mepc_i = '0;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    int checks = 0;
    int failures = 0;

    tmu_ctrl dut (
        .cpu_clock_i(cpu_clock_i), .cpu_reset_i(cpu_reset_i),
        .csr_valid_i(csr_valid_i), .csr_ready_o(csr_ready_o),
        .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i), .csr_wdata_i(csr_wdata_i),
        .commit_pc_i(commit_pc_i),
        .csr_resp_valid_o(csr_resp_valid_o), .csr_rdata_o(csr_rdata_o),
        .excp_valid_i(excp_valid_i), .excp_code_i(excp_code_i), .excp_tval_i(excp_tval_i),
        .mret_i(mret_i),
        .tmu_valid_o(tmu_valid_o), .tmu_address_o(tmu_address_o), .tmu_opcode_o(tmu_opcode_o),
        .tmu_wr_en_o(tmu_wr_en_o), .tmu_data_o(tmu_data_o),
        .tmu_done_i(tmu_done_i), .tmu_excp_i(tmu_excp_i), .tmu_rdata_i(tmu_rdata_i),
        .take_exception_o(take_exception_o), .take_interrupt_o(take_interrupt_o), .mret_o(mret_o),
        .tmu_epc_o(tmu_epc_o), .tmu_mtval_o(tmu_mtval_o), .tmu_mcause_o(tmu_mcause_o),
        .mip_i(mip_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    always #5 cpu_clock_i = ~cpu_clock_i;

    task automatic tick();
        @(posedge cpu_clock_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        cpu_reset_i = 1'b1;
        tick();
        tick();
        cpu_reset_i = 1'b0;
        #1;
        check("rst_ready", 32'(csr_ready_o), 32'd0);
        check("rst_tmu_valid", 32'(tmu_valid_o), 32'd0);
        check("rst_resp", 32'(csr_resp_valid_o), 32'd0);
        check("rst_take_exc", 32'(take_exception_o), 32'd0);
        check("rst_redirect", 32'(redirect_valid_o), 32'd0);

        // MSCRATCH write: tmu_valid at N+1, done at N+2, response at N+3
        commit_pc_i = 30'h40;
        csr_valid_i = 1'b1;
        csr_addr_i  = 12'h340;
        csr_op_i    = 3'b101;
        csr_wdata_i = 32'hDEADBEEF;
        #1;
        check("wr_ready", 32'(csr_ready_o), 32'd1);
        tick();
        csr_valid_i = 1'b0;
        check("wr_tmu_valid", 32'(tmu_valid_o), 32'd1);
        check("wr_addr", 32'(tmu_address_o), 32'h340);
        check("wr_opcode", 32'(tmu_opcode_o), 32'd1);
        check("wr_wren", 32'(tmu_wr_en_o), 32'd1);
        check("wr_data", tmu_data_o, 32'hDEADBEEF);
        tick();
        check("wr_valid_single", 32'(tmu_valid_o), 32'd0);
        tmu_done_i  = 1'b1;
        tmu_rdata_i = 32'h12345678;
        tick();
        tmu_done_i = 1'b0;
        check("wr_resp", 32'(csr_resp_valid_o), 32'd1);
        check("wr_rdata", csr_rdata_o, 32'h12345678);
        check("wr_no_trap", 32'(take_exception_o), 32'd0);
        tick();
        check("wr_resp_single", 32'(csr_resp_valid_o), 32'd0);

        // stray done in IDLE is ignored
        tmu_done_i = 1'b1;
        tmu_excp_i = 1'b1;
        tick();
        tmu_done_i = 1'b0;
        tmu_excp_i = 1'b0;
        check("stray_resp", 32'(csr_resp_valid_o), 32'd0);
        check("stray_trap", 32'(take_exception_o), 32'd0);

        // illegal CSR access traps with cause 2
        mtvec_i     = 32'h00001003;
        commit_pc_i = 30'h100;
        csr_valid_i = 1'b1;
        csr_addr_i  = 12'h300;
        csr_op_i    = 3'b010;
        csr_wdata_i = 32'h0000_0008;
        tick();
        csr_valid_i = 1'b0;
        commit_pc_i = 30'h555;
        check("ill_wren", 32'(tmu_wr_en_o), 32'd0);
        check("ill_opcode", 32'(tmu_opcode_o), 32'd2);
        tick();
        tmu_done_i = 1'b1;
        tmu_excp_i = 1'b1;
        tick();
        tmu_done_i = 1'b0;
        tmu_excp_i = 1'b0;
        check("ill_take_exc", 32'(take_exception_o), 32'd1);
        check("ill_no_resp", 32'(csr_resp_valid_o), 32'd0);
        check("ill_mcause", 32'(tmu_mcause_o), 32'd2);
        check("ill_epc", 32'(tmu_epc_o), 32'h100);
        check("ill_mtval", tmu_mtval_o, 32'd0);
        tick();
        check("ill_pulse_single", 32'(take_exception_o), 32'd0);
        check("ill_redirect", 32'(redirect_valid_o), 32'd1);
        check("ill_redirect_pc", redirect_pc_o, 32'h00001000);
        tick();
        check("ill_redirect_single", 32'(redirect_valid_o), 32'd0);

        // exception wins over MRET and CSR
        commit_pc_i  = 30'h200;
        excp_valid_i = 1'b1;
        excp_code_i  = 4'd5;
        excp_tval_i  = 32'hCAFEF00D;
        mret_i       = 1'b1;
        csr_valid_i  = 1'b1;
        #1;
        check("pri_ready", 32'(csr_ready_o), 32'd0);
        tick();
        check("pri_take_exc", 32'(take_exception_o), 32'd1);
        check("pri_no_mret", 32'(mret_o), 32'd0);
        check("pri_no_csr", 32'(tmu_valid_o), 32'd0);
        check("pri_mcause", 32'(tmu_mcause_o), 32'd5);
        check("pri_mtval", tmu_mtval_o, 32'hCAFEF00D);
        check("pri_epc", 32'(tmu_epc_o), 32'h200);
        tick();
        excp_valid_i = 1'b0;
        mret_i       = 1'b0;
        csr_valid_i  = 1'b0;
        check("pri_redirect_pc", redirect_pc_o, 32'h00001000);
        tick();
        tick();
        check("pri_idle_no_csr", 32'(tmu_valid_o), 32'd0);

        // MRET returns to mepc
        mepc_i = 30'h3FFFFFFF;
        mret_i = 1'b1;
        tick();
        check("mret_pulse", 32'(mret_o), 32'd1);
        check("mret_no_exc", 32'(take_exception_o), 32'd0);
        tick();
        mret_i = 1'b0;
        check("mret_redirect", 32'(redirect_valid_o), 32'd1);
        check("mret_redirect_pc", redirect_pc_o, 32'hFFFFFFFC);
        tick();

        // interrupt: MEI has top priority
        mtvec_i     = 32'h80000001;
        commit_pc_i = 30'h300;
        mip_i       = 3'b111;
        mie_i       = 1'b1;
        tick();
        mie_i = 1'b0;
        check("irq_take", 32'(take_interrupt_o), 32'd1);
        check("irq_mcause", 32'(tmu_mcause_o), 32'd11);
        check("irq_epc", 32'(tmu_epc_o), 32'h300);
        check("irq_mtval", tmu_mtval_o, 32'd0);
        tick();
`ifdef TMU_VECTORED_EN
        check("irq_redirect_pc", redirect_pc_o, 32'h8000002C);
`else
        check("irq_redirect_pc", redirect_pc_o, 32'h80000000);
`endif
        tick();

        // MSI beats MTI; masked by mie_i until enabled
        mip_i = 3'b011;
        tick();
        check("irq_masked", 32'(take_interrupt_o), 32'd0);
        mie_i = 1'b1;
        tick();
        mie_i = 1'b0;
        check("irq_msi_cause", 32'(tmu_mcause_o), 32'd3);
        tick();
        tick();
        mip_i = 3'b000;

        // reset mid CSR_WAIT, then a stray done
        commit_pc_i = 30'h77;
        csr_valid_i = 1'b1;
        csr_addr_i  = 12'h341;
        csr_op_i    = 3'b101;
        csr_wdata_i = 32'hA5A5A5A5;
        tick();
        csr_valid_i = 1'b0;
        tick();
        cpu_reset_i = 1'b1;
        tick();
        cpu_reset_i = 1'b0;
        tmu_done_i  = 1'b1;
        tmu_rdata_i = 32'hFFFFFFFF;
        tick();
        tmu_done_i = 1'b0;
        check("rstw_resp", 32'(csr_resp_valid_o), 32'd0);
        check("rstw_rdata", csr_rdata_o, 32'd0);
        check("rstw_tmu_valid", 32'(tmu_valid_o), 32'd0);
        check("rstw_addr", 32'(tmu_address_o), 32'd0);
        check("rstw_data", tmu_data_o, 32'd0);
        check("rstw_epc", 32'(tmu_epc_o), 32'd0);
        check("rstw_mcause", 32'(tmu_mcause_o), 32'd0);
        check("rstw_mtval", tmu_mtval_o, 32'd0);
        check("rstw_redirect_pc", redirect_pc_o, 32'd0);
        tick();
        check("rstw_resp_late", 32'(csr_resp_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tmu_ctrl.md
TMU_CTRL -- requirements
Module: tmu_ctrl

Interface
REQ-001 Ports SHALL be (name  direction  width  meaning); no parameters. One clock; reset is synchronous and active-high.
 cpu_clock_i  in  1  core clock; all state updates on rising edge
 cpu_reset_i  in  1  synchronous active-high reset
 csr_valid_i  in  1  commit head holds a CSR instruction
 csr_ready_o  out  1  CSR request accepted this cycle
 csr_addr_i  in  12  CSR address
 csr_op_i  in  3  [1:0] 01 RW/10 RS/11 RC; [2] write enable
 csr_wdata_i  in  32  rs1/immediate operand
 commit_pc_i  in  30  word PC of commit-head instruction
 csr_resp_valid_o  out  1  one-cycle CSR result strobe
 csr_rdata_o  out  32  old CSR value for rd
 excp_valid_i  in  1  commit-head exception, held until redirect
 excp_code_i  in  4  exception cause
 excp_tval_i  in  32  exception mtval
 mret_i  in  1  commit-head MRET, held until redirect
 tmu_valid_o  out  1  CSR-file access strobe
 tmu_address_o  out  12  CSR-file address
 tmu_opcode_o  out  2  CSR-file opcode
 tmu_wr_en_o  out  1  CSR-file write enable
 tmu_data_o  out  32  CSR-file operand
 tmu_done_i  in  1  CSR-file completion
 tmu_excp_i  in  1  CSR-file illegal-access flag, valid with done
 tmu_rdata_i  in  32  CSR-file read data, valid with done
 take_exception_o  out  1  trap-entry strobe, exception
 take_interrupt_o  out  1  trap-entry strobe, interrupt
 mret_o  out  1  trap-return strobe
 tmu_epc_o  out  30  trap EPC
 tmu_mtval_o  out  32  trap mtval
 tmu_mcause_o  out  4  trap cause code
 mip_i  in  3  enabled pending {MEI,MTI,MSI}
 mie_i  in  1  mstatus.MIE
 mtvec_i  in  32  trap vector CSR
 mepc_i  in  30  MEPC CSR
 redirect_valid_o  out  1  one-cycle fetch-redirect strobe
 redirect_pc_o  out  32  redirect target

Function
REQ-002 FSM states SHALL be IDLE, CSR_REQ, CSR_WAIT, CSR_RESP, PULSE, REDIR. csr_ready_o = IDLE & csr_valid_i & !excp_valid_i & !mret_i.
REQ-003 IDLE priority SHALL be: exception > MRET > CSR > interrupt, where interrupt = mie_i & |mip_i. Exception latches code/tval/commit_pc_i -> PULSE. MRET -> PULSE. Interrupt latches epc=commit_pc_i, mtval=0, cause MEI=11 > MSI=3 > MTI=7 -> PULSE.
REQ-004 CSR accepted at edge N: tmu_valid_o=1 only in cycle N+1 with registered addr/op/data. tmu_wr_en_o=csr_op_i[2]. CSR_WAIT holds until tmu_done_i. If !tmu_excp_i: csr_resp_valid_o=1 for one cycle with captured rdata (N+3 nominal), then IDLE. If tmu_excp_i: trap with cause 2, mtval 0, epc = request PC -> PULSE.
REQ-005 PULSE SHALL assert exactly one of take_exception_o/take_interrupt_o/mret_o for one cycle with epc/mtval/mcause stable. REDIR follows next cycle: one-cycle redirect_valid_o, then IDLE.
REQ-006 Redirect target: MRET {mepc_i,2'b00}; exception {mtvec_i[31:2],2'b00}; interrupt per REQ-009. Address arithmetic is 30-bit wrap-around.
REQ-007 tmu_done_i outside CSR_WAIT SHALL be ignored. No new request is accepted outside IDLE. All strobes are single-cycle.

Reset
REQ-008 cpu_reset_i SHALL force IDLE and zero all outputs and latched registers at the next edge, including mid-operation; a subsequent stray tmu_done_i is ignored.

Configuration
REQ-009 TMU_VECTORED_EN defined: an interrupt with mtvec_i[1:0]==01 redirects to {mtvec_i[31:2]+cause,2'b00}. Undefined: all traps use the base address; mtvec_i[1:0] is ignored.

Verification
REQ-010 Write MSCRATCH (0x340, op 3'b101, data 0xDEADBEEF) -> tmu_valid_o at N+1, done at N+2, csr_resp_valid_o at N+3; no trap.
REQ-011 CSR access with tmu_excp_i=1, commit_pc_i=0x100 -> take_exception_o with mcause 2, epc 0x100, mtval 0, then redirect to mtvec base.
REQ-012 excp_valid_i, mret_i and csr_valid_i asserted together in IDLE -> only exception processed; csr_ready_o=0.
REQ-013 mip_i=3'b111, mie_i=1, mtvec_i=0x80000001 -> cause 11; redirect 0x8000002C with TMU_VECTORED_EN, 0x80000000 without.
REQ-014 Reset asserted in CSR_WAIT, then done pulse -> IDLE, no csr_resp_valid_o, all outputs 0.
